// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding and byte/word helpers
// for the iterative encryption core and its round datapath.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int AES_NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Element 0 is the most significant byte, so SBOX[b] is S(b).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational forward AES round
// (SubBytes, ShiftRows, MixColumns unless last, AddRoundKey).
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    // Byte i of the packed arrays is FIPS-197 state byte i (row i%4, column i/4).
    logic [0:15][7:0] sb, sr, mc;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
            // 2a ^ 3b ^ c ^ d written as xtime(a ^ b) ^ b ^ c ^ d
            assign mc[4*c+r] = xtime(sr[4*c+r] ^ sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                             ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
        end
    end

    assign next_state = (last ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption, one round per clock,
// with on-the-fly key expansion and valid/ready on both sides.
module aes128_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int RCW        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic         busy
);

    if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
        $error("aes128_encrypt_iter supports only NUM_ROUNDS = 10");
    end

    fsm_t             fsm, fsm_next;
    logic [RCW-1:0]   rnd;
    logic [127:0]     state_reg, rk_reg, rk_next, round_out;
    logic [31:0]      w0, w1, w2, w3;
    logic [7:0]       rc;
    logic             armed;
    logic             last;

    assign last = rnd == RCW'(AES_NR);
    assign rc   = (rnd != '0 && rnd <= RCW'(AES_NR)) ? RCON[rnd] : 8'h00;

    assign w0      = rk_reg[127:96] ^ sub_word(rot_word(rk_reg[31:0])) ^ {rc, 24'h0};
    assign w1      = rk_reg[95:64] ^ w0;
    assign w2      = rk_reg[63:32] ^ w1;
    assign w3      = rk_reg[31:0] ^ w2;
    assign rk_next = {w0, w1, w2, w3};

    aes_enc_round u_round (
        .state      (state_reg),
        .round_key  (rk_next),
        .last       (last),
        .next_state (round_out)
    );

    // armed holds in_ready low for the first cycle after reset release.
    assign in_ready    = armed && fsm == IDLE;
    assign out_valid   = fsm == DONE;
    assign busy        = fsm == RUN;
    assign cipher_text = state_reg;

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    fsm_next = (in_valid && in_ready) ? RUN : IDLE;
            RUN:     fsm_next = last ? DONE : RUN;
            DONE:    fsm_next = out_ready ? IDLE : DONE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            rk_reg    <= '0;
            armed     <= 1'b0;
        end else begin
            fsm   <= fsm_next;
            armed <= 1'b1;
            if (fsm == IDLE && in_valid && in_ready) begin
                state_reg <= plain_text ^ key;
                rk_reg    <= key;
                rnd       <= RCW'(1);
            end else if (fsm == RUN) begin
                state_reg <= round_out;
                rk_reg    <= rk_next;
                rnd       <= last ? '0 : rnd + RCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb_aes128_encrypt_iter: known-answer, handshake and randomized checks of
// the iterative AES-128 core against a behavioural FIPS-197 model.
module tb_aes128_encrypt_iter;

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] plain_text = '0, key = '0, cipher_text;
    int           total = 0, bad = 0, cyc = 0;
    logic [7:0]   sb_tab [256];

    aes128_encrypt_iter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plain_text  (plain_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk, o;
        rk = round_key(k, 0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = p[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
        for (int n = 1; n <= 10; n++) begin
            rk = round_key(k, n);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sb_tab[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = ((n == 10) ? t[r][c] :
                               gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^
                               t[(r+2)%4][c] ^ t[(r+3)%4][c]) ^ rk[127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic [127:0] p, input logic [127:0] k);
        int n = 0;
        @(negedge clk);
        plain_text = p;
        key        = k;
        in_valid   = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen; returns at a negedge.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        check("out_valid_seen", out_valid, 1);
    endtask

    // Called at a negedge with out_valid high.
    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        int           lat, n, t0, t1;
        logic         seen;
        logic [127:0] p, k, e;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cipher", cipher_text, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 1);

        send(C1_P, C1_K);
        wait_out(lat);
        check("c1_latency", lat, 10);
        check("c1_cipher", cipher_text, C1_C);
        finish_out();

        send(B_P, B_K);
        @(negedge clk);
        check("b_busy", busy, 1);
        check("b_in_ready_run", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("b_rk1", dut.rk_reg, B_RK1);
        wait_out(lat);
        check("b_latency", lat, 9);
        check("b_cipher", cipher_text, B_C);
        finish_out();

        send(C1_P, C1_K);
        plain_text = '1;
        key        = '1;
        wait_out(lat);
        check("chg_cipher", cipher_text, C1_C);
        finish_out();

        send(B_P, B_K);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = (i == 5);
            if (i == 5) begin
                plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
                key        = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            check("bp_out_valid", out_valid, 1);
            check("bp_cipher", cipher_text, B_C);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        finish_out();
        check("bp_no_start", busy, 0);

        @(negedge clk);
        out_ready  = 1'b1;
        plain_text = C1_P;
        key        = C1_K;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        plain_text = B_P;
        key        = B_K;
        n    = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                check("b2b_first_cipher", cipher_text, C1_C);
            end
        end while (!in_ready && n < 40);
        t1 = cyc;
        check("b2b_first_seen", seen, 1);
        check("b2b_gap", t1 - t0, 12);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        check("b2b_second_latency", lat, 10);
        check("b2b_second_cipher", cipher_text, B_C);
        finish_out();

        send(B_P, B_K);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cipher", cipher_text, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_release_in_ready", in_ready, 1);
        send(C1_P, C1_K);
        wait_out(lat);
        check("after_rst_latency", lat, 10);
        check("after_rst_cipher", cipher_text, C1_C);
        finish_out();

        for (int i = 0; i < 25; i++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            e = ref_encrypt(p, k);
            send(p, k);
            wait_out(lat);
            check("rand_latency", lat, 10);
            check("rand_cipher", cipher_text, e);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand_hold", cipher_text, e);
            end
            finish_out();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption core; the forward counterpart of the decryption round datapath.
- Computes one full AES round per clock, with on-the-fly forward key expansion.
- Uses a valid/ready handshake on both the input side (plaintext + key) and the output side (ciphertext).
- Sits beside the decryption path. It reuses the existing forward subbytes/shiftrows/mixcolumns/addRoundKey primitives via one round sub-module.

Parameters:
- NUM_ROUNDS, 10, AES round count; only 10 (AES-128) is supported, and elaboration must fail on any other value.
- RCW, 4, width of the round counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  core can accept a block.
- plain_text  in  128  FIPS-197 byte order, [127:120] = byte 0, column-major state.
- key  in  128  cipher key, same byte order.
- out_valid  out  1  cipher_text valid.
- out_ready  in  1  downstream accepts cipher_text.
- cipher_text  out  128  encrypted block.
- busy  out  1  high while rounds are in progress.

Behaviour:
- Reset (async, active-high): FSM=IDLE, round counter=0, state and round-key registers=0, in_ready=0 while reset is asserted, out_valid=0, cipher_text=0, busy=0. After reset deasserts, in_ready=1 on the next cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge N: state_reg <= plain_text ^ key (initial AddRoundKey), rk_reg <= key, rnd <= 1, go to RUN.
- RUN:
  - Each cycle: rk_next = expand(rk_reg, rcon[rnd]), where rcon = 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
  - state_reg <= round(state_reg, rk_next, last = (rnd == 10)). When last is set, MixColumns is bypassed.
  - rk_reg <= rk_next, rnd <= rnd + 1.
  - After the rnd==10 update, go to DONE.
  - busy=1 and in_ready=0 throughout RUN.
  - Inputs are ignored during RUN; plain_text and key need not be held after the accept.
- DONE:
  - out_valid=1 and cipher_text=state_reg, both stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - No new input is accepted in DONE (in_ready=0). Back-to-back throughput is therefore one block per 12 cycles when out_ready is held high.
- Latency: accept at edge N gives out_valid=1 after edge N+10 (10 RUN cycles). The first possible cipher_text handshake is edge N+11.
- Key expansion for AES-128:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 00, 00, 00}.
  - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - w0 = rk[127:96].
- The round counter never exceeds 10, so there is no wrap-around. Any out-of-range FSM encoding must return to IDLE.
- Reset mid-RUN or mid-DONE aborts the block. No output handshake occurs for the aborted block, and all outputs return to their reset values immediately.
- cipher_text is registered. There is no combinational path from inputs to outputs, except that in_ready and out_valid are decoded from FSM state only.

Decomposition:
- Shared package aes_pkg holds:
  - state and FSM encoding typedef {IDLE, RUN, DONE};
  - AES_NR = 10;
  - RCON constant array [1:10];
  - forward S-box function or table;
  - SubWord/RotWord helpers.
- Sub-module aes_enc_round (combinational): inputs state, round_key, last; output next_state. It instantiates the forward subbytes → shiftrows → mixcolumns (bypassed when last) → addRoundKey.
- Key expansion stays inline in the top module. It needs four extra S-box instances.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff → cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising exactly 10 cycles after accept.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. After round 1, internal rk must equal a0fafe1788542cb123a339392a6c7605.
- Output backpressure: hold out_ready=0 for 20 cycles after out_valid → cipher_text and out_valid stable, in_ready=0, and a new in_valid pulse is ignored. Releasing out_ready gives one handshake, then IDLE.
- Back-to-back: two blocks (C.1 then App. B) with out_ready=1 and in_valid held → both correct in order, second accept exactly 12 cycles after the first.
- Reset mid-RUN: assert reset at round 5 → out_valid=0, busy=0, cipher_text=0 immediately. After release, C.1 runs correctly with no stale output.
- Input change after accept: change plain_text/key to all-ones on the cycle after accept → result is still the original C.1 ciphertext.
